// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and sizes for the dmem arbiter
package dmem_arbiter_pkg;
  localparam int ARB_NPORTS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] we;
    logic [DW-1:0] wdata;
    logic          port;
  } arb_req_t;
endpackage

// File: rtl/dmem_arbiter_rr_grant.sv
// rr_grant: one-hot grant for two ports; DMEM_ARB_RR_EN selects round-robin, else port 0 fixed priority
module rr_grant
  import dmem_arbiter_pkg::*;
(
  input  logic [ARB_NPORTS-1:0] req_valid,
  input  logic                  last,
  output logic [ARB_NPORTS-1:0] grant
);
`ifdef DMEM_ARB_RR_EN
  assign grant = &req_valid ? (last ? 2'b01 : 2'b10) : req_valid;
`else
  logic unused_last;
  assign unused_last = last;
  assign grant = &req_valid ? 2'b01 : req_valid;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two masters onto one dmem as IDLE->ISSUE->RESP; DMEM_ARB_RR_EN picks round-robin
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ARB_NPORTS-1:0] req_valid,
  output logic [ARB_NPORTS-1:0] req_ready,
  input  logic [AW-1:0]         req_addr0,
  input  logic [AW-1:0]         req_addr1,
  input  logic [BW-1:0]         req_we0,
  input  logic [BW-1:0]         req_we1,
  input  logic [DW-1:0]         req_wdata0,
  input  logic [DW-1:0]         req_wdata1,
  output logic [ARB_NPORTS-1:0] rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic [AW-1:0]         mem_addr,
  output logic [BW-1:0]         mem_we,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
);
  arb_state_t            state;
  arb_req_t              lat;
  logic                  last;
  logic [ARB_NPORTS-1:0] grant;

  rr_grant u_grant (.req_valid(req_valid), .last(last), .grant(grant));

  assign req_ready = state == IDLE ? grant : '0;
  assign mem_we    = state == ISSUE ? lat.we : '0;
  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;
  assign rsp_rdata = (state == RESP && lat.we == '0) ? mem_rdata : '0;

  // access sequencer: latch on accept, one issue cycle, one response pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat       <= '0;
      last      <= 1'b1;
      rsp_valid <= '0;
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          lat   <= req_ready[1] ? '{req_addr1, req_we1, req_wdata1, 1'b1}
                                : '{req_addr0, req_we0, req_wdata0, 1'b0};
          state <= ISSUE;
        end
        ISSUE: begin
          rsp_valid <= {lat.port, ~lat.port};
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= '0;
          last      <= lat.port;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios against a byte-writable synchronous dmem model
module tb_dmem_arbiter;
  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [3:0]  req_we0 = '0, req_we1 = '0;
  logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:255];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_we0(req_we0), .req_we1(req_we1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous dmem: read data appears the cycle after the address
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic run_access(input int p, input logic [31:0] a, input logic [3:0] we,
                            input logic [31:0] wd, output logic [1:0] rdy,
                            output logic [3:0] we_iss, output logic [31:0] addr_iss,
                            output logic [31:0] wdata_iss, output logic [1:0] rsp,
                            output logic [31:0] rdata, output logic [3:0] we_rsp,
                            output int acc, output int rcyc);
    @(posedge clk); #1;
    if (p == 0) begin req_addr0 = a; req_we0 = we; req_wdata0 = wd; req_valid = 2'b01; end
    else begin req_addr1 = a; req_we1 = we; req_wdata1 = wd; req_valid = 2'b10; end
    @(negedge clk);
    rdy = req_ready; acc = cyc;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    we_iss = mem_we; addr_iss = mem_addr; wdata_iss = mem_wdata;
    @(posedge clk); #1;
    @(negedge clk);
    rsp = rsp_valid; rdata = rsp_rdata; we_rsp = mem_we; rcyc = cyc;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we got %b exp 0000", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_port0_read;
    logic [1:0] rdy, rsp; logic [3:0] wi, wr; logic [31:0] ai, di, rd; int acc, rc;
    run_access(0, 32'h10, 4'h0, 32'h0, rdy, wi, ai, di, rsp, rd, wr, acc, rc);
    checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL rd0_ready got %b exp 01", rdy); end
    checks++; if (wi !== 4'h0) begin errors++; $display("FAIL rd0_mem_we got %b exp 0000", wi); end
    checks++; if (ai !== 32'h10) begin errors++; $display("FAIL rd0_mem_addr got %h exp 10", ai); end
    checks++; if (rsp !== 2'b01) begin errors++; $display("FAIL rd0_rsp_valid got %b exp 01", rsp); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_rdata got %h exp deadbeef", rd); end
    checks++; if (rc - acc !== 2) begin errors++; $display("FAIL rd0_latency got %0d exp 2", rc - acc); end
  endtask

  task automatic test_byte_write;
    logic [1:0] rdy, rsp; logic [3:0] wi, wr; logic [31:0] ai, di, rd; int acc, rc;
    run_access(1, 32'h20, 4'b0001, 32'h55555555, rdy, wi, ai, di, rsp, rd, wr, acc, rc);
    checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL wr1_ready got %b exp 10", rdy); end
    checks++; if (wi !== 4'b0001) begin errors++; $display("FAIL wr1_mem_we got %b exp 0001", wi); end
    checks++; if (ai !== 32'h20) begin errors++; $display("FAIL wr1_mem_addr got %h exp 20", ai); end
    checks++; if (di !== 32'h55555555) begin errors++; $display("FAIL wr1_mem_wdata got %h exp 55555555", di); end
    checks++; if (wr !== 4'b0000) begin errors++; $display("FAIL wr1_we_after got %b exp 0000", wr); end
    checks++; if (rsp !== 2'b10) begin errors++; $display("FAIL wr1_rsp_valid got %b exp 10", rsp); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr1_rdata got %h exp 0", rd); end
    run_access(0, 32'h20, 4'h0, 32'h0, rdy, wi, ai, di, rsp, rd, wr, acc, rc);
    checks++; if (rd !== 32'hAABBCC55) begin errors++; $display("FAIL wr1_readback got %h exp aabbcc55", rd); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] rdy, rsp; logic [3:0] wi, wr; logic [31:0] ai, di, rd; int acc, rc, acc0;
    logic [31:0] exp_d [3];
    exp_d = '{32'h11111111, 32'h22222222, 32'h33333333};
    for (int k = 0; k < 3; k++) begin
      run_access(0, 32'h40 + 32'(4*k), 4'h0, 32'h0, rdy, wi, ai, di, rsp, rd, wr, acc, rc);
      if (k == 0) acc0 = acc;
      checks++; if (acc - acc0 !== 3*k) begin errors++; $display("FAIL b2b_accept%0d got %0d exp %0d", k, acc - acc0, 3*k); end
      checks++; if (rc - acc0 !== 3*k + 2) begin errors++; $display("FAIL b2b_rsp%0d got %0d exp %0d", k, rc - acc0, 3*k + 2); end
      checks++; if (rd !== exp_d[k]) begin errors++; $display("FAIL b2b_rdata%0d got %h exp %h", k, rd, exp_d[k]); end
    end
  endtask

  task automatic test_reset_mid_access;
    @(posedge clk); #1;
    req_addr1 = 32'h28; req_we1 = 4'hF; req_wdata1 = 32'hCAFEF00D; req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (mem_we !== 4'hF) begin errors++; $display("FAIL rst_issue_we got %b exp 1111", mem_we); end
    #2 reset = 1;
    #1;
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL rst_we_drop got %b exp 0000", mem_we); end
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_rsp got %b exp 00", rsp_valid); end
    @(posedge clk); #1;
    reset = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_rsp_after%0d got %b exp 00", k, rsp_valid); end
    end
    checks++; if (mem[10] !== 32'h0) begin errors++; $display("FAIL rst_no_write got %h exp 0", mem[10]); end
  endtask

  task automatic test_contention;
    logic [1:0] exp_g [4];
`ifdef DMEM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    @(posedge clk); #1;
    req_addr0 = 32'h10; req_we0 = 4'h0; req_addr1 = 32'h24; req_we1 = 4'h0; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== exp_g[k]) begin errors++; $display("FAIL cont_grant%0d got %b exp %b", k, req_ready, exp_g[k]); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (mem_addr !== (exp_g[k][1] ? 32'h24 : 32'h10)) begin errors++; $display("FAIL cont_addr%0d got %h", k, mem_addr); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cont_busy%0d got %b exp 00", k, req_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (rsp_valid !== exp_g[k]) begin errors++; $display("FAIL cont_rsp%0d got %b exp %b", k, rsp_valid, exp_g[k]); end
      checks++; if (rsp_rdata !== (exp_g[k][1] ? 32'h12345678 : 32'hDEADBEEF)) begin errors++; $display("FAIL cont_rdata%0d got %h", k, rsp_rdata); end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_dropped;
    @(posedge clk); #1;
    req_addr0 = 32'h10; req_we0 = 4'h0; req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL drop_grant got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_addr1 = 32'h2C; req_we1 = 4'hF; req_wdata1 = 32'hFFFFFFFF; req_valid = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drop_ready got %b exp 00", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL drop_rsp0 got %b exp 01", rsp_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b00 || mem_we !== 4'h0) begin errors++; $display("FAIL drop_idle%0d got rsp %b we %b exp 00 0000", k, rsp_valid, mem_we); end
    end
    checks++; if (mem[11] !== 32'h0) begin errors++; $display("FAIL drop_no_write got %h exp 0", mem[11]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4]  = 32'hDEADBEEF;
    mem[8]  = 32'hAABBCCDD;
    mem[9]  = 32'h12345678;
    mem[16] = 32'h11111111;
    mem[17] = 32'h22222222;
    mem[18] = 32'h33333333;
    test_reset;
    test_port0_read;
    test_byte_write;
    test_back_to_back;
    test_reset_mid_access;
    test_contention;
    test_dropped;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
